// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the IF/ID queue.
// master = fetch + control + decode side, slave = the queue itself.
interface if_id_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              id_stall;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, if_valid, if_pc, if_inst, id_stall,
    input  if_ready, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  flush, if_valid, if_pc, if_inst, id_stall,
    output if_ready, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of (pc, inst) pairs between fetch and decode.
// Fetch keeps running while decode stalls; flush empties the queue in one
// cycle; decode sees an all-zero bubble whenever nothing is valid.
// Optional macro IF_ID_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// pair is forwarded combinationally to decode in the same cycle.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  if_id_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pcMem   [DEPTH];
  logic [INST_W-1:0] instMem [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic queueValid;
  logic readyInt;
  logic bypassHit;
  logic bypassTake;
  logic doPush;
  logic doPop;

  assign queueValid = (cnt_q != '0);
  assign readyInt   = (cnt_q != FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypassHit  = ~queueValid & bus.if_valid & ~bus.flush;
  assign bypassTake = bypassHit & ~bus.id_stall;
`else
  assign bypassHit  = 1'b0;
  assign bypassTake = 1'b0;
`endif

  // A bypassed pair that decode consumes immediately is never written.
  assign doPush = bus.if_valid & readyInt & ~bus.flush & ~bypassTake;
  assign doPop  = queueValid & ~bus.id_stall & ~bus.flush;

  assign bus.if_ready = readyInt;
  assign bus.count    = cnt_q;

  // Head of queue (or bypassed pair) to decode, zero bubble otherwise.
  always_comb begin
    bus.id_valid = 1'b0;
    bus.id_pc    = '0;
    bus.id_inst  = '0;
    if (queueValid) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = pcMem[rp_q];
      bus.id_inst  = instMem[rp_q];
    end else if (bypassHit) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = bus.if_pc;
      bus.id_inst  = bus.if_inst;
    end
  end

  // Next pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (doPush) wp_d = wp_q + PTR_W'(1);
      if (doPop)  rp_d = rp_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      pcMem[wp_q]   <= bus.if_pc;
      instMem[wp_q] <= bus.if_inst;
    end
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch stage and the decode stage as a DEPTH-entry FIFO of (pc, inst) pairs.
- Lets fetch keep running while decode is stalled.
- Supports a single-cycle flush on branch/jump redirect and presents a zero bubble to decode when empty.

Parameters:
- ADDR_W, 32, width of pc field.
- INST_W, 32, width of instruction field.
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  redirect from ctrl; discards all queued entries.
- if_valid  input  1  fetch presents a valid (pc, inst) this cycle.
- if_pc  input  ADDR_W  fetched pc.
- if_inst  input  INST_W  fetched instruction.
- if_ready  output  1  queue can accept a push this cycle.
- id_stall  input  1  decode cannot consume this cycle.
- id_valid  output  1  id_pc/id_inst hold a real instruction.
- id_pc  output  ADDR_W  head pc; zero when id_valid=0.
- id_inst  output  INST_W  head instruction; zero (bubble) when id_valid=0.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH-entry array; write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy register cnt, 0..DEPTH.
- Reset (rst=1, asynchronous): wp=0, rp=0, cnt=0, so if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0. Array contents need not reset.
- if_ready = (cnt != DEPTH). Purely from state; no combinational path from id_stall.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & ~id_stall & ~flush.
- On push: entry[wp] <= {if_pc, if_inst}; wp <= wp+1.
- On pop: rp <= rp+1.
- cnt updates by +1 (push only), -1 (pop only), or unchanged (both or neither).
- Simultaneous push and pop:
  - Legal whenever cnt is in 1..DEPTH-1.
  - When cnt=DEPTH, if_ready=0, so no push occurs.
  - When cnt=0, id_valid=0, so no pop occurs (base build).
- Outputs: id_valid = (cnt != 0). id_pc/id_inst = entry[rp] when id_valid, else zero.
- Latency: an instruction pushed in cycle N is visible on id_* in cycle N+1 (base build).
- Flush:
  - At the next rising edge: wp=0, rp=0, cnt=0.
  - A push or pop in the same cycle as flush is discarded.
  - id_valid=0 from the following cycle.
- Flush while id_stall=1: flush wins.
- Reset mid-operation: immediate clear regardless of clk, flush or stall.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across the wrap.
- count = cnt.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- When defined:
  - If cnt=0, if_valid=1 and flush=0, the incoming pair is driven combinationally onto id_pc/id_inst and id_valid=1 in the same cycle.
  - If id_stall=0 that cycle, the pair is consumed: no write, and pointers and cnt are unchanged.
  - If id_stall=1, the pair is also pushed normally and appears again from the queue next cycle.
- When undefined: no bypass path; minimum latency is 1 cycle, as described in Behaviour.

Test Plan:
- Reset: rst=1 asynchronously, mid-cycle, with cnt=3 -> immediately id_valid=0, id_inst=0, count=0, if_ready=1.
- Fill/drain ordering: push pc 0x00,0x04,0x08,0x0C with id_stall=1 -> count=4, if_ready=0; a fifth push is refused. Release id_stall -> id_pc sequence 0x00,0x04,0x08,0x0C, then id_valid=0.
- Wrap and concurrency: DEPTH=4, run 10 back-to-back pushes with pops every cycle after the first -> id_pc follows 0x00..0x24 in order, count stays 1, no loss.
- Flush with stall: count=3, id_stall=1, flush=1 with if_valid=1 (pc 0x40) -> next cycle count=0, id_valid=0, and 0x40 is not stored.
- Empty bubble: no pushes for 5 cycles -> id_valid=0, id_pc=0, id_inst=0 throughout.
- Bypass, macro defined: cnt=0, if_valid=1, pc 0x80, inst 0x00000013, id_stall=0 -> same cycle id_valid=1, id_pc=0x80; next cycle count=0. Repeat with id_stall=1 -> next cycle count=1, id_pc=0x80.
